// File: rtl/audio_pkt_fifo.sv
// Single-clock packet FIFO for the audio-to-UDP path: writes stay tentative until the
// last beat commits them, so the reader only ever sees whole packets.
module audio_pkt_fifo #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 10,
    parameter int OUT_REG          = 1,
    parameter int ALMOST_FULL_NUM  = 1013,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_wr_last,
    input  logic                  i_wr_drop,
    output logic                  o_full,
    output logic                  o_almost_full,
    output logic [ADDR_WIDTH:0]   o_wr_water_level,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_last,
    output logic                  o_rd_valid,
    output logic                  o_empty,
    output logic                  o_almost_empty,
    output logic [ADDR_WIDTH:0]   o_rd_water_level,
    output logic [ADDR_WIDTH:0]   o_pkt_cnt,
    output logic                  o_drop_pulse
);

    localparam int              DEPTH    = 2 ** ADDR_WIDTH;
    localparam int              PW       = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
    localparam logic [PW-1:0]   DEPTH_P  = PW'(DEPTH);
    localparam logic [31:0]     AF_TH    = ALMOST_FULL_NUM;
    localparam logic [31:0]     AE_TH    = ALMOST_EMPTY_NUM;

    logic [DATA_WIDTH:0] r_mem [DEPTH];

    logic [PW-1:0] r_wr_ptr, r_commit_ptr, r_rd_ptr, r_pkt_cnt;
    logic [PW-1:0] w_wr_ptr_next, w_commit_ptr_next, w_rd_ptr_next, w_pkt_cnt_next;
    logic          r_ovf, w_ovf_next;
    logic          r_drop_pulse;

    logic [PW-1:0] w_wr_level, w_rd_level;
    logic          w_full, w_empty;
    logic          w_wr_accept, w_ovf_hit, w_drop, w_commit, w_rd_accept, w_pkt_dec;

    logic [DATA_WIDTH:0] r_s1_word;
    logic                r_s1_valid;
    logic [DATA_WIDTH:0] w_out_word;
    logic                w_out_valid;

    assign w_wr_level = r_wr_ptr - r_rd_ptr;
    assign w_rd_level = r_commit_ptr - r_rd_ptr;
    assign w_full     = (w_wr_level == DEPTH_P);
    assign w_empty    = (w_rd_level == '0);

    // A last beat that lands while overflowed (or overflows right now) throws the packet away.
    assign w_wr_accept = i_wr_en & ~w_full & ~i_wr_drop;
    assign w_ovf_hit   = i_wr_en & w_full & ~i_wr_drop;
    assign w_drop      = i_wr_drop | (i_wr_en & i_wr_last & (r_ovf | w_full));
    assign w_commit    = w_wr_accept & i_wr_last & ~r_ovf;
    assign w_rd_accept = i_rd_en & ~w_empty;
    assign w_pkt_dec   = w_out_valid & w_out_word[DATA_WIDTH];

    always_comb begin
        w_wr_ptr_next     = r_wr_ptr;
        w_commit_ptr_next = r_commit_ptr;
        w_rd_ptr_next     = r_rd_ptr;
        w_ovf_next        = r_ovf;
        w_pkt_cnt_next    = r_pkt_cnt;

        if (w_drop) begin
            w_wr_ptr_next = r_commit_ptr;
            w_ovf_next    = 1'b0;
        end else begin
            if (w_wr_accept) w_wr_ptr_next = r_wr_ptr + PTR_ONE;
            if (w_ovf_hit)   w_ovf_next    = 1'b1;
        end

        if (w_commit)    w_commit_ptr_next = r_wr_ptr + PTR_ONE;
        if (w_rd_accept) w_rd_ptr_next     = r_rd_ptr + PTR_ONE;

        case ({w_commit, w_pkt_dec})
            2'b10:   w_pkt_cnt_next = r_pkt_cnt + PTR_ONE;
            2'b01:   w_pkt_cnt_next = r_pkt_cnt - PTR_ONE;
            default: w_pkt_cnt_next = r_pkt_cnt;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_pkt_cnt    <= '0;
            r_ovf        <= 1'b0;
            r_drop_pulse <= 1'b0;
        end else begin
            r_wr_ptr     <= w_wr_ptr_next;
            r_commit_ptr <= w_commit_ptr_next;
            r_rd_ptr     <= w_rd_ptr_next;
            r_pkt_cnt    <= w_pkt_cnt_next;
            r_ovf        <= w_ovf_next;
            r_drop_pulse <= w_drop;
        end
    end

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge i_clk) begin
        if (w_wr_accept) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= {i_wr_last, i_wr_data};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_word  <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_rd_accept;
            if (w_rd_accept) r_s1_word <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH:0] r_out_word;
            logic                r_out_valid;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_out_word  <= '0;
                    r_out_valid <= 1'b0;
                end else begin
                    r_out_valid <= r_s1_valid;
                    if (r_s1_valid) r_out_word <= r_s1_word;
                end
            end

            assign w_out_word  = r_out_word;
            assign w_out_valid = r_out_valid;
        end else begin : g_no_out_reg
            assign w_out_word  = r_s1_word;
            assign w_out_valid = r_s1_valid;
        end
    endgenerate

    assign o_full           = w_full;
    assign o_almost_full    = (32'(w_wr_level) >= AF_TH);
    assign o_wr_water_level = w_wr_level;
    assign o_empty          = w_empty;
    assign o_almost_empty   = (32'(w_rd_level) <= AE_TH);
    assign o_rd_water_level = w_rd_level;
    assign o_rd_data        = w_out_word[DATA_WIDTH-1:0];
    assign o_rd_last        = w_out_word[DATA_WIDTH];
    assign o_rd_valid       = w_out_valid;
    assign o_pkt_cnt        = r_pkt_cnt;
    assign o_drop_pulse     = r_drop_pulse;

endmodule

// File: tb/tb_audio_pkt_fifo.sv
// Scoreboard bench for audio_pkt_fifo: a 16-deep instance with output register and a
// second instance without it, both driven by the same stimulus.
module tb_audio_pkt_fifo;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0, wr_last = 1'b0, wr_drop = 1'b0, rd_en = 1'b0;
    logic [DW-1:0] wr_data = '0;

    logic          full, almost_full, rd_last, rd_valid, empty, almost_empty, drop_pulse;
    logic [AW:0]   wr_level, rd_level, pkt_cnt;
    logic [DW-1:0] rd_data;

    logic          z_full, z_almost_full, z_rd_last, z_rd_valid, z_empty, z_almost_empty, z_drop_pulse;
    logic [AW:0]   z_wr_level, z_rd_level, z_pkt_cnt;
    logic [DW-1:0] z_rd_data;

    audio_pkt_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(1),
                     .ALMOST_FULL_NUM(13), .ALMOST_EMPTY_NUM(2)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .i_wr_last(wr_last), .i_wr_drop(wr_drop), .o_full(full), .o_almost_full(almost_full),
        .o_wr_water_level(wr_level), .i_rd_en(rd_en), .o_rd_data(rd_data), .o_rd_last(rd_last),
        .o_rd_valid(rd_valid), .o_empty(empty), .o_almost_empty(almost_empty),
        .o_rd_water_level(rd_level), .o_pkt_cnt(pkt_cnt), .o_drop_pulse(drop_pulse));

    audio_pkt_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(0),
                     .ALMOST_FULL_NUM(13), .ALMOST_EMPTY_NUM(2)) u_dut_noreg (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .i_wr_last(wr_last), .i_wr_drop(wr_drop), .o_full(z_full), .o_almost_full(z_almost_full),
        .o_wr_water_level(z_wr_level), .i_rd_en(rd_en), .o_rd_data(z_rd_data), .o_rd_last(z_rd_last),
        .o_rd_valid(z_rd_valid), .o_empty(z_empty), .o_almost_empty(z_almost_empty),
        .o_rd_water_level(z_rd_level), .o_pkt_cnt(z_pkt_cnt), .o_drop_pulse(z_drop_pulse));

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [DW:0] exp_q[$];
    logic [DW:0] pend_q[$];
    int          exp_pkt = 0;
    bit          commit_flag = 1'b0;
    bit          dec_flag = 1'b0;
    bit          chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_beat(input logic [DW-1:0] d, input bit last, input bit commit);
        wr_en   = 1'b1;
        wr_data = d;
        wr_last = last;
        pend_q.push_back({last, d});
        tick();
        wr_en   = 1'b0;
        wr_last = 1'b0;
        if (commit) begin
            commit_flag = 1'b1;
            foreach (pend_q[k]) exp_q.push_back(pend_q[k]);
            pend_q.delete();
        end
    endtask

    task automatic drain(input string name, input int budget);
        for (int k = 0; k < budget && exp_q.size() != 0; k++) tick();
        repeat (3) tick();
        check(name, 32'(exp_q.size()), 0);
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_empty"}, 32'(empty), 1);
        check({tag, "_almost_empty"}, 32'(almost_empty), 1);
        check({tag, "_full"}, 32'(full), 0);
        check({tag, "_almost_full"}, 32'(almost_full), 0);
        check({tag, "_wr_level"}, 32'(wr_level), 0);
        check({tag, "_rd_level"}, 32'(rd_level), 0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 0);
        check({tag, "_rd_data"}, 32'(rd_data), 0);
        check({tag, "_rd_last"}, 32'(rd_last), 0);
        check({tag, "_pkt_cnt"}, 32'(pkt_cnt), 0);
        check({tag, "_drop_pulse"}, 32'(drop_pulse), 0);
        check({tag, "_noreg_rd_valid"}, 32'(z_rd_valid), 0);
        check({tag, "_noreg_empty"}, 32'(z_empty), 1);
    endtask

    // Monitor: pops the scoreboard on every rd_valid and tracks the packet count model.
    always @(negedge clk) begin : mon
        logic [DW:0] e;
        if (chk_en) begin
            exp_pkt     = exp_pkt + int'(commit_flag) - int'(dec_flag);
            commit_flag = 1'b0;
            dec_flag    = 1'b0;
            check("pkt_cnt", 32'(pkt_cnt), 32'(exp_pkt));
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rd_valid", 32'(rd_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", 32'(rd_data), 32'(e[DW-1:0]));
                    check("rd_last", 32'(rd_last), 32'(e[DW]));
                    if (e[DW]) dec_flag = 1'b1;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int len;

        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();

        // Single 8-beat packet, latency 2 on the registered output.
        for (int i = 1; i <= 8; i++) begin
            wr_beat(DW'(i), i == 8, i == 8);
            if (i == 7) check("t1_empty_precommit", 32'(empty), 1);
        end
        check("t1_rd_level", 32'(rd_level), 8);
        check("t1_wr_level", 32'(wr_level), 8);
        check("t1_empty", 32'(empty), 0);
        check("t1_almost_empty", 32'(almost_empty), 0);
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) check("t1_lat_edge0", 32'(rd_valid), 0);
            if (i == 1) begin
                check("t1_lat_edge1", 32'(rd_valid), 1);
                check("t1_first_data", 32'(rd_data), 1);
            end
        end
        rd_en = 1'b0;
        check("t1_empty_after_reads", 32'(empty), 1);
        drain("t1_drain", 20);
        check("t1_pkt_cnt_end", 32'(pkt_cnt), 0);
        check("t1_rd_data_hold", 32'(rd_data), 8);

        // Explicit drop of a 5-beat partial packet, then a clean 3-beat packet.
        for (int i = 0; i < 5; i++) wr_beat(DW'(16'h50 + i), 1'b0, 1'b0);
        check("t2_wr_level_5", 32'(wr_level), 5);
        check("t2_empty_uncommitted", 32'(empty), 1);
        wr_drop = 1'b1;
        tick();
        wr_drop = 1'b0;
        pend_q.delete();
        check("t2_drop_pulse", 32'(drop_pulse), 1);
        check("t2_wr_level_0", 32'(wr_level), 0);
        tick();
        check("t2_drop_pulse_clear", 32'(drop_pulse), 0);
        wr_beat(16'h000A, 1'b0, 1'b0);
        wr_beat(16'h000B, 1'b0, 1'b0);
        wr_beat(16'h000C, 1'b1, 1'b1);
        rd_en = 1'b1;
        drain("t2_drain", 20);
        rd_en = 1'b0;

        // Oversized packet (DEPTH+4 beats) overflows and is dropped at its last beat.
        for (int i = 0; i < 20; i++) begin
            wr_beat(DW'(16'h100 + i), i == 19, 1'b0);
            if (i == 11) begin
                check("t3_level_12", 32'(wr_level), 12);
                check("t3_af_below", 32'(almost_full), 0);
            end
            if (i == 12) begin
                check("t3_af_at_13", 32'(almost_full), 1);
                check("t3_not_full_13", 32'(full), 0);
            end
            if (i == 15) begin
                check("t3_full_16", 32'(full), 1);
                check("t3_level_16", 32'(wr_level), 16);
                check("t3_empty_while_full", 32'(empty), 1);
            end
            if (i == 17) check("t3_level_held", 32'(wr_level), 16);
            if (i == 18) check("t3_no_early_drop", 32'(drop_pulse), 0);
        end
        pend_q.delete();
        check("t3_drop_pulse", 32'(drop_pulse), 1);
        check("t3_wr_level_0", 32'(wr_level), 0);
        check("t3_empty", 32'(empty), 1);
        check("t3_full_clear", 32'(full), 0);
        check("t3_pkt_cnt", 32'(pkt_cnt), 0);
        tick();
        check("t3_drop_pulse_clear", 32'(drop_pulse), 0);

        // Three packets written while reading continuously; pointers wrap.
        rd_en = 1'b1;
        cnt   = 0;
        for (int p = 0; p < 3; p++) begin
            len = (p == 1) ? 14 : 13;
            for (int b = 0; b < len; b++) begin
                wr_beat(DW'(16'h200 + cnt), b == len - 1, b == len - 1);
                cnt++;
            end
        end
        drain("t4_drain", 60);
        rd_en = 1'b0;
        check("t4_empty", 32'(empty), 1);

        // rd_en held while empty, and in the same cycle as the commit.
        rd_en = 1'b1;
        repeat (3) tick();
        check("t5_rd_level_idle", 32'(rd_level), 0);
        check("t5_no_valid_idle", 32'(rd_valid), 0);
        check("t5_noreg_no_valid_idle", 32'(z_rd_valid), 0);
        wr_beat(16'h0777, 1'b1, 1'b1);
        check("t5_valid_commit_edge", 32'(rd_valid), 0);
        check("t5_noreg_valid_commit_edge", 32'(z_rd_valid), 0);
        check("t5_not_empty", 32'(empty), 0);
        tick();
        check("t5_valid_edge1", 32'(rd_valid), 0);
        check("t5_noreg_valid_edge1", 32'(z_rd_valid), 1);
        check("t5_noreg_data", 32'(z_rd_data), 32'h777);
        check("t5_noreg_last", 32'(z_rd_last), 1);
        tick();
        check("t5_valid_edge2", 32'(rd_valid), 1);
        check("t5_noreg_single", 32'(z_rd_valid), 0);
        rd_en = 1'b0;
        drain("t5_drain", 10);

        // Reset mid-read and mid-packet, then a clean packet.
        for (int i = 0; i < 4; i++) wr_beat(DW'(16'h30 + i), i == 3, i == 3);
        rd_en = 1'b1;
        wr_beat(16'h0060, 1'b0, 1'b0);
        wr_beat(16'h0061, 1'b0, 1'b0);
        rd_en = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        pend_q.delete();
        exp_pkt     = 0;
        commit_flag = 1'b0;
        dec_flag    = 1'b0;
        #1;
        chk_reset("t6");
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) wr_beat(DW'(16'h40 + i), i == 2, i == 2);
        check("t6_rd_level", 32'(rd_level), 3);
        rd_en = 1'b1;
        drain("t6_drain", 20);
        rd_en = 1'b0;
        check("t6_pkt_cnt_end", 32'(pkt_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
